mult32_seq: RTL and testbench

Sequential unsigned 32x32->64 shift-and-add multiplier built around the existing `adder32` block. It takes operands through a valid/ready input handshake and runs one partial-product step per clock through a single `adder32` instance, using all 33 sum bits. It returns the 64-bit product through a valid/ready output handshake. It sits directly downstream of `adder32` and is the first sequential consumer of that block's carry-out.

---
 rtl/mult32_seq.sv | 103 ++++++++++
 tb/tb_mult32_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult32_seq.sv
// mult32_seq: sequential unsigned 32x32->64 shift-and-add multiplier.
// Operands arrive on a valid/ready handshake, one partial-product step runs
// per clock through a single adder32, and the product leaves on a second
// valid/ready handshake. The adder's carry-out feeds the top product bit.

// adder32: 32-bit unsigned adder producing a 33-bit sum (carry-out in bit 32).
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [32:0] sum
);

  // Zero-extend both operands so the carry lands in sum[32].
  assign sum = {1'b0, a} + {1'b0, b};

endmodule

module mult32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [63:0] prod;
  logic [5:0]  count;
  logic [31:0] addend;
  logic [32:0] sum;

  // Add the multiplicand only when the current multiplier bit (prod[0]) is set.
  assign addend = prod[0] ? mcand : 32'd0;

  adder32 u_adder (
    .a   (prod[63:32]),
    .b   (addend),
    .sum (sum)
  );

  // The output register is the product register itself.
  assign product = prod;

  // Control FSM and datapath: accept, 32 shift-and-add steps, hold result.
  // NOTE: every register here is assigned with <= so all of them update
  // together from the values they held before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mcand     <= '0;
      prod      <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            prod     <= {32'd0, b};
            count    <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // The 33-bit sum, carry included, becomes the new upper half while
          // the consumed multiplier bit shifts out at the bottom.
          prod  <= {sum, prod[31:1]};
          count <= count + 6'd1;
          if (count == 6'd31) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult32_seq.sv
// tb_mult32_seq: self-checking bench for mult32_seq. A cycle-level model of
// the handshake timing plus plain 64-bit multiplication predicts the outputs;
// directed operations pin the model with literal expectations.
`timescale 1ns/1ps

module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] product;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  mult32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase of the current operation, steps remaining and
  // the arithmetic product it will deliver.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     m_ph   = M_IDLE;
  int          m_left = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_prod = '0;

  // Model advances on each rising edge from the bench-driven inputs.
  always @(posedge clk) begin
    if (!rst) begin
      m_ph   = M_IDLE;
      m_prod = '0;
    end else begin
      case (m_ph)
        M_IDLE: if (in_valid) begin
          m_pend = {32'd0, a} * {32'd0, b};
          m_left = 32;
          m_ph   = M_BUSY;
        end
        M_BUSY: begin
          m_left--;
          if (m_left == 0) begin
            m_ph   = M_DONE;
            m_prod = m_pend;
          end
        end
        M_DONE: if (out_ready) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // Compare DUT against the model every cycle, mid-cycle.
  always @(negedge clk) begin
    if (checking) begin
      check("cyc_in_ready", in_ready, m_ph == M_IDLE);
      check("cyc_out_valid", out_valid, m_ph == M_DONE);
      if (m_ph != M_BUSY) check("cyc_product", product, m_prod);
    end
  end

  // One full operation: accept, wait for the result, stall, then hand it off.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [63:0] exp, input int stall,
                       input bit chk_lat, input bit junk);
    int n;
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", n < 100, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", n < 100, 1'b1);
    if (chk_lat) check("latency", n, 32);
    check("product", product, exp);
    if (junk) begin
      in_valid = 1'b1;
      a = 32'd2;
      b = 32'd2;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_product", product, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("handshake_product", product, {32'd0, ta} * {32'd0, tb_v});
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_in_ready", in_ready, 1'b1);
    check("post_out_valid", out_valid, 1'b0);
    check("post_product", product, exp);
  endtask

  initial begin
    bit seen_valid;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset held two cycles with live operands on the inputs.
    rst = 1'b0;
    in_valid = 1'b1;
    a = 32'd5;
    b = 32'd7;
    @(posedge clk); #1;
    checking = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_product", product, 64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_nothing_accepted", in_ready, 1'b1);

    // Zero operands with exact latency, then boundary products.
    do_op(32'd0, 32'd0, 64'd0, 0, 1'b1, 1'b0);
    do_op(32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 0, 1'b1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 1'b0, 1'b0);

    // Backpressure with junk operands offered while the result is held.
    do_op(32'd6, 32'd7, 64'd42, 5, 1'b0, 1'b1);

    // Reset after 10 busy steps aborts the operation.
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_product", product, 64'd0);
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_valid", seen_valid, 1'b0);
    do_op(32'd3, 32'd5, 64'd15, 0, 1'b1, 1'b0);

    // Random operand pairs with random consumer stalls.
    for (int i = 0; i < 200; i++) begin
      ra = $random;
      rb = $random;
      do_op(ra, rb, {32'd0, ra} * {32'd0, rb}, $urandom_range(0, 3), 1'b1, 1'b0);
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
